spio_status_led_decoder: RTL and testbench

SPIO_STATUS_LED_DECODER -- requirements
Module: spio_status_led_decoder

---
 rtl/spio_status_led_pkg.sv | 24 ++
 rtl/spio_status_led_duty_meter.sv | 102 ++++++++++
 rtl/spio_status_led_decoder.sv | 139 +++++++++++++
 tb/tb_spio_status_led_decoder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spio_status_led_pkg.sv
// Shared encodings for the status LED decoder: FSM states and PWM window classes.
package spio_status_led_pkg;

   localparam logic [1:0] ST_UNSYNC  = 2'd0;
   localparam logic [1:0] ST_ARMED   = 2'd1;
   localparam logic [1:0] ST_MEASURE = 2'd2;

   typedef enum logic [1:0] {
      FULL_OFF = 2'd0,
      FULL_ON  = 2'd1,
      PARTIAL  = 2'd2
   } win_class_t;

   // Width-agnostic window classification from the two boundary tests.
   function automatic win_class_t classify_window(input logic all_on, input logic all_off);
      if (all_on)
         return FULL_ON;
      else if (all_off)
         return FULL_OFF;
      else
         return PARTIAL;
   endfunction

endpackage

// File: rtl/spio_status_led_duty_meter.sv
// Per-device PWM duty measurement: classifies each completed window and
// accumulates per-period statistics, then decodes the status at publish.
module spio_status_led_duty_meter
   import spio_status_led_pkg::*;
#(
   parameter int PWM_BITS              = 7,
   parameter int ACC_BITS              = 21,
   parameter int BLINK_MIN_TRANSITIONS = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_led,
   input  logic i_win_end,
   input  logic i_period_start,
   input  logic i_publish,
   input  logic i_flush,
   output logic o_error,
   output logic o_connected,
   output logic o_activity
);

   localparam logic [PWM_BITS:0]   DUTY_FULL = {1'b1, {PWM_BITS{1'b0}}};
   localparam logic [ACC_BITS-1:0] ACC_ONE   = ACC_BITS'(1);

   logic [PWM_BITS:0]   r_duty;
   logic [PWM_BITS:0]   w_duty_total;
   win_class_t          w_class;
   logic [ACC_BITS-1:0] r_on_cnt;
   logic [ACC_BITS-1:0] r_off_cnt;
   logic [ACC_BITS-1:0] r_part_cnt;
   logic [2:0]          r_trans_cnt;
   logic                r_last_valid;
   win_class_t          r_last_full;
   logic [ACC_BITS:0]   w_full_sum;
   logic                w_blink;
   logic                w_mostly_partial;
   logic                w_mostly_on;

   // Count of high cycles including the current one, so the window's last cycle is not lost.
   assign w_duty_total = r_duty + (PWM_BITS+1)'(i_led);
   assign w_class      = classify_window(w_duty_total == DUTY_FULL, w_duty_total == '0);

   // Duty counter restarts at every window end and at every period start.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_duty <= '0;
      else if (i_period_start || i_win_end)
         r_duty <= '0;
      else
         r_duty <= w_duty_total;
   end

   // Per-period statistics; partial windows never count toward transitions.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_on_cnt     <= '0;
         r_off_cnt    <= '0;
         r_part_cnt   <= '0;
         r_trans_cnt  <= '0;
         r_last_valid <= 1'b0;
         r_last_full  <= FULL_OFF;
      end else if (i_period_start) begin
         r_on_cnt     <= '0;
         r_off_cnt    <= '0;
         r_part_cnt   <= '0;
         r_trans_cnt  <= '0;
         r_last_valid <= 1'b0;
         r_last_full  <= FULL_OFF;
      end else if (i_win_end) begin
         case (w_class)
            FULL_ON:  if (r_on_cnt   != '1) r_on_cnt   <= r_on_cnt   + ACC_ONE;
            FULL_OFF: if (r_off_cnt  != '1) r_off_cnt  <= r_off_cnt  + ACC_ONE;
            default:  if (r_part_cnt != '1) r_part_cnt <= r_part_cnt + ACC_ONE;
         endcase
         if (w_class != PARTIAL) begin
            if (r_last_valid && (w_class != r_last_full) && (r_trans_cnt != 3'd7))
               r_trans_cnt <= r_trans_cnt + 3'd1;
            r_last_full  <= w_class;
            r_last_valid <= 1'b1;
         end
      end
   end

   assign w_full_sum       = {1'b0, r_on_cnt} + {1'b0, r_off_cnt};
   assign w_blink          = {29'd0, r_trans_cnt} >= 32'(BLINK_MIN_TRANSITIONS);
   assign w_mostly_partial = {1'b0, r_part_cnt} > w_full_sum;
   assign w_mostly_on      = r_on_cnt > r_off_cnt;

   // Status flags latch the prioritised decision at publish and drop on watchdog expiry.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst || i_flush) begin
         o_error     <= 1'b0;
         o_connected <= 1'b0;
         o_activity  <= 1'b0;
      end else if (i_publish) begin
         o_activity  <= w_blink;
         o_connected <= w_blink || w_mostly_partial;
         o_error     <= !w_blink && !w_mostly_partial && w_mostly_on;
      end
   end

endmodule

// File: rtl/spio_status_led_decoder.sv
// Status LED decoder: recovers error/connected/activity from PWM LED lines.
// Optional input synchroniser enabled by SPIO_STATUS_LED_DECODER_SYNC_EN.
module spio_status_led_decoder
   import spio_status_led_pkg::*;
#(
   parameter int NUM_DEVICES           = 1,
   parameter int ANIMATION_PERIOD_BITS = 27,
   parameter int PWM_BITS              = 7,
   parameter int BLINK_MIN_TRANSITIONS = 4
) (
   input  logic                   CLK_IN,
   input  logic                   RESET_IN,
   input  logic [NUM_DEVICES-1:0] LED_IN,
   input  logic                   ANIMATION_REPEAT_IN,
   output logic [NUM_DEVICES-1:0] ERROR_OUT,
   output logic [NUM_DEVICES-1:0] CONNECTED_OUT,
   output logic [NUM_DEVICES-1:0] ACTIVITY_OUT,
   output logic                   LOCKED_OUT,
   output logic                   VALID_OUT
);

   localparam int ACC_BITS = ANIMATION_PERIOD_BITS - PWM_BITS + 1;
   localparam int WD_BITS  = ANIMATION_PERIOD_BITS + 1;
   localparam logic [WD_BITS-1:0] WD_LAST = '1;
   localparam logic [WD_BITS-1:0] WD_PRE  = {{(WD_BITS-1){1'b1}}, 1'b0};

   logic [NUM_DEVICES-1:0] w_led;
   logic                   w_repeat;
   logic [PWM_BITS-1:0]    r_win_cnt;
   logic                   w_win_end;
   logic [WD_BITS-1:0]     r_wd;
   logic                   w_wd_expire;
   logic [1:0]             r_state;
   logic                   w_publish;
   logic                   r_valid;

`ifdef SPIO_STATUS_LED_DECODER_SYNC_EN
   logic [NUM_DEVICES-1:0] r_led_meta;
   logic [NUM_DEVICES-1:0] r_led_sync;
   logic                   r_rep_meta;
   logic                   r_rep_sync;

   // Two-flop synchronisers for inputs from another clock domain.
   always_ff @(posedge CLK_IN or posedge RESET_IN) begin
      if (RESET_IN) begin
         r_led_meta <= '0;
         r_led_sync <= '0;
         r_rep_meta <= 1'b0;
         r_rep_sync <= 1'b0;
      end else begin
         r_led_meta <= LED_IN;
         r_led_sync <= r_led_meta;
         r_rep_meta <= ANIMATION_REPEAT_IN;
         r_rep_sync <= r_rep_meta;
      end
   end

   assign w_led    = r_led_sync;
   assign w_repeat = r_rep_sync;
`else
   assign w_led    = LED_IN;
   assign w_repeat = ANIMATION_REPEAT_IN;
`endif

   // A repeat pulse kills the window in flight, so no window ends in that cycle.
   assign w_win_end = (r_win_cnt == '1) && !w_repeat;

   // Shared PWM window counter aligned to the animation period.
   always_ff @(posedge CLK_IN or posedge RESET_IN) begin
      if (RESET_IN)
         r_win_cnt <= '0;
      else if (w_repeat)
         r_win_cnt <= '0;
      else
         r_win_cnt <= r_win_cnt + PWM_BITS'(1);
   end

   // Expiry fires on the edge at which the watchdog reaches its terminal count.
   assign w_wd_expire = (r_wd == WD_PRE) && !w_repeat;

   // Watchdog on the spacing of repeat pulses; holds at the terminal count.
   always_ff @(posedge CLK_IN or posedge RESET_IN) begin
      if (RESET_IN)
         r_wd <= '0;
      else if (w_repeat)
         r_wd <= '0;
      else if (r_wd != WD_LAST)
         r_wd <= r_wd + WD_BITS'(1);
   end

   // Lock FSM: two repeat pulses needed before results are trusted.
   always_ff @(posedge CLK_IN or posedge RESET_IN) begin
      if (RESET_IN)
         r_state <= ST_UNSYNC;
      else if (w_wd_expire)
         r_state <= ST_UNSYNC;
      else if (w_repeat) begin
         case (r_state)
            ST_UNSYNC:  r_state <= ST_ARMED;
            ST_ARMED:   r_state <= ST_MEASURE;
            ST_MEASURE: r_state <= ST_MEASURE;
            default:    r_state <= ST_UNSYNC;
         endcase
      end
   end

   assign w_publish = w_repeat && (r_state == ST_MEASURE);

   // One-cycle update strobe following each publishing repeat pulse.
   always_ff @(posedge CLK_IN or posedge RESET_IN) begin
      if (RESET_IN)
         r_valid <= 1'b0;
      else
         r_valid <= w_publish;
   end

   for (genvar g = 0; g < NUM_DEVICES; g++) begin : g_meter
      spio_status_led_duty_meter #(
         .PWM_BITS              (PWM_BITS),
         .ACC_BITS              (ACC_BITS),
         .BLINK_MIN_TRANSITIONS (BLINK_MIN_TRANSITIONS)
      ) u_meter (
         .i_clk          (CLK_IN),
         .i_rst          (RESET_IN),
         .i_led          (w_led[g]),
         .i_win_end      (w_win_end),
         .i_period_start (w_repeat),
         .i_publish      (w_publish),
         .i_flush        (w_wd_expire),
         .o_error        (ERROR_OUT[g]),
         .o_connected    (CONNECTED_OUT[g]),
         .o_activity     (ACTIVITY_OUT[g])
      );
   end

   assign LOCKED_OUT = (r_state == ST_MEASURE);
   assign VALID_OUT  = r_valid;

endmodule

// File: tb/tb_spio_status_led_decoder.sv
// Self-checking bench for spio_status_led_decoder with a queue-based reference model.
module tb_spio_status_led_decoder;

   localparam int APB = 12;
   localparam int PWM = 3;
   localparam int WIN = 1 << PWM;
   localparam int PERIOD = 1 << APB;
   localparam int WD_LIMIT = (1 << (APB + 1)) - 1;

   logic       clk = 1'b0;
   logic       rst;
   logic [0:0] led_in;
   logic       rep;
   logic [0:0] err_out;
   logic [0:0] con_out;
   logic [0:0] act_out;
   logic       locked;
   logic       valid;

   always #5 clk = ~clk;

   spio_status_led_decoder #(
      .NUM_DEVICES           (1),
      .ANIMATION_PERIOD_BITS (APB),
      .PWM_BITS              (PWM),
      .BLINK_MIN_TRANSITIONS (4)
   ) dut (
      .CLK_IN              (clk),
      .RESET_IN            (rst),
      .LED_IN              (led_in),
      .ANIMATION_REPEAT_IN (rep),
      .ERROR_OUT           (err_out),
      .CONNECTED_OUT       (con_out),
      .ACTIVITY_OUT        (act_out),
      .LOCKED_OUT          (locked),
      .VALID_OUT           (valid)
   );

   int total = 0;
   int bad   = 0;

   // Reference model state
   bit          m_samples[$];
   int          m_reps;
   int          m_since;
   bit          m_err, m_con, m_act, m_valid;
   int          m_mode;
   int          m_kind;
   int unsigned m_chg;
   int          valid_seen;

   // Classify a period's samples window by window and derive the expected flags.
   function automatic void judge();
      int on = 0, off = 0, part = 0, trans = 0, last = -1;
      int n, s, cls;
      n = m_samples.size() / WIN;
      for (int w = 0; w < n; w++) begin
         s = 0;
         for (int k = 0; k < WIN; k++) s += int'(m_samples[w*WIN+k]);
         cls = (s == WIN) ? 1 : (s == 0) ? 0 : 2;
         if (cls == 1) on++;
         else if (cls == 0) off++;
         else part++;
         if (cls != 2) begin
            if (last != -1 && last != cls) trans++;
            last = cls;
         end
      end
      if (trans > 7) trans = 7;
      m_err = 0; m_con = 0; m_act = 0;
      if (trans >= 4) begin m_con = 1; m_act = 1; end
      else if (part > on + off) m_con = 1;
      else if (on > off) m_err = 1;
   endfunction

   // LED stream imitating the status generator for the selected mode.
   task automatic next_led(output bit led);
      int idx;
      idx = m_samples.size();
      case (m_mode)
         0: led = 1'b0;
         1: led = 1'b1;
         2: led = (idx % WIN) < 3;
         3: led = ((idx / 50) % 2) == 0;
         default: begin
            if ((idx % WIN) == 0 && $urandom_range(0, 99) < m_chg)
               m_kind = int'($urandom_range(0, 2));
            case (m_kind)
               0: led = 1'b0;
               1: led = 1'b1;
               default: led = bit'($urandom_range(0, 1));
            endcase
         end
      endcase
   endtask

   // One clock: drive inputs, advance the model, sample after the edge.
   task automatic step(input bit r);
      bit l;
      next_led(l);
      led_in = l;
      rep = r;
      m_valid = 0;
      if (r) begin
         if (m_reps >= 2) begin judge(); m_valid = 1; end
         if (m_reps < 2) m_reps++;
         m_samples.delete();
         m_since = 0;
      end else begin
         m_samples.push_back(l);
         m_since++;
         if (m_since == WD_LIMIT) begin
            m_reps = 0; m_err = 0; m_con = 0; m_act = 0;
         end
      end
      @(posedge clk);
      #1;
      if (valid) valid_seen++;
   endtask

   task automatic model_reset();
      m_samples.delete();
      m_reps = 0; m_since = 0;
      m_err = 0; m_con = 0; m_act = 0; m_valid = 0;
   endtask

   task automatic test_reset();
      total++; if (err_out !== 1'b0) begin bad++; $display("FAIL reset_err: got %0b want 0", err_out); end
      total++; if (con_out !== 1'b0) begin bad++; $display("FAIL reset_con: got %0b want 0", con_out); end
      total++; if (act_out !== 1'b0) begin bad++; $display("FAIL reset_act: got %0b want 0", act_out); end
      total++; if (locked  !== 1'b0) begin bad++; $display("FAIL reset_locked: got %0b want 0", locked); end
      total++; if (valid   !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", valid); end
      rst = 1'b0;
      model_reset();
      repeat (5) step(0);
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL post_reset_locked: got %0b want 0", locked); end
   endtask

   task automatic test_error();
      m_mode = 1;
      step(1);
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL err_lock_1st: got %0b want 0", locked); end
      repeat (PERIOD - 1) step(0);
      step(1);
      total++; if (locked !== 1'b1) begin bad++; $display("FAIL err_lock_2nd: got %0b want 1", locked); end
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL err_valid_2nd: got %0b want 0", valid); end
      repeat (PERIOD - 1) step(0);
      step(1);
      total++; if (valid !== 1'b1) begin bad++; $display("FAIL err_valid_3rd: got %0b want 1", valid); end
      total++; if ({err_out, con_out, act_out} !== 3'b100)
         begin bad++; $display("FAIL err_flags: got e%0b c%0b a%0b want e1 c0 a0", err_out, con_out, act_out); end
      step(0);
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL err_valid_width: got %0b want 0", valid); end
   endtask

   task automatic test_activity();
      m_mode = 3;
      repeat (PERIOD - 2) step(0);
      step(1);
      repeat (PERIOD - 1) step(0);
      step(1);
      total++; if ({err_out, con_out, act_out} !== 3'b011)
         begin bad++; $display("FAIL act_flags: got e%0b c%0b a%0b want e0 c1 a1", err_out, con_out, act_out); end
      total++; if (valid !== 1'b1) begin bad++; $display("FAIL act_valid: got %0b want 1", valid); end
   endtask

   task automatic test_connected();
      m_mode = 2;
      repeat (PERIOD - 1) step(0);
      step(1);
      total++; if ({err_out, con_out, act_out} !== 3'b010)
         begin bad++; $display("FAIL con_flags: got e%0b c%0b a%0b want e0 c1 a0", err_out, con_out, act_out); end
   endtask

   task automatic test_idle();
      m_mode = 0;
      repeat (PERIOD - 1) step(0);
      step(1);
      valid_seen = 0;
      repeat (2) begin
         repeat (PERIOD - 1) step(0);
         step(1);
      end
      total++; if (valid_seen != 2) begin bad++; $display("FAIL idle_valid_count: got %0d want 2", valid_seen); end
      total++; if ({err_out, con_out, act_out} !== 3'b000)
         begin bad++; $display("FAIL idle_flags: got e%0b c%0b a%0b want 0", err_out, con_out, act_out); end
   endtask

   task automatic test_random();
      int len;
      m_mode = 4;
      for (int it = 0; it < 16; it++) begin
         m_chg = $urandom_range(0, 30);
         m_kind = int'($urandom_range(0, 2));
         len = int'($urandom_range(1, 500));
         repeat (len - 1) step(0);
         step(1);
         total++; if (valid !== m_valid) begin bad++; $display("FAIL rnd_valid[%0d]: got %0b want %0b", it, valid, m_valid); end
         total++; if (locked !== (m_reps >= 2)) begin bad++; $display("FAIL rnd_locked[%0d]: got %0b want %0b", it, locked, m_reps >= 2); end
         total++; if ({err_out, con_out, act_out} !== {m_err, m_con, m_act})
            begin bad++; $display("FAIL rnd_flags[%0d]: got %b%b%b want %b%b%b", it, err_out, con_out, act_out, m_err, m_con, m_act); end
      end
   endtask

   task automatic test_back_to_back();
      m_mode = 1;
      step(1);
      for (int i = 0; i < 3; i++) begin
         step(1);
         total++; if (valid !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d]: got %0b want 1", i, valid); end
         total++; if ({err_out, con_out, act_out} !== 3'b000)
            begin bad++; $display("FAIL b2b_flags[%0d]: got %b%b%b want 000", i, err_out, con_out, act_out); end
      end
   endtask

   task automatic test_watchdog();
      m_mode = 1;
      repeat (PERIOD - 1) step(0);
      step(1);
      total++; if (err_out !== 1'b1) begin bad++; $display("FAIL wd_pre_err: got %0b want 1", err_out); end
      valid_seen = 0;
      repeat (WD_LIMIT - 1) step(0);
      total++; if (locked !== 1'b1) begin bad++; $display("FAIL wd_before_locked: got %0b want 1", locked); end
      total++; if (err_out !== 1'b1) begin bad++; $display("FAIL wd_before_err: got %0b want 1", err_out); end
      step(0);
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL wd_expired_locked: got %0b want 0", locked); end
      total++; if ({err_out, con_out, act_out} !== 3'b000)
         begin bad++; $display("FAIL wd_expired_flags: got %b%b%b want 000", err_out, con_out, act_out); end
      total++; if (valid_seen != 0) begin bad++; $display("FAIL wd_valid_count: got %0d want 0", valid_seen); end
      // re-lock with consecutive pulses
      step(1);
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL relock_1st: got %0b want 0", locked); end
      step(1);
      total++; if (locked !== 1'b1) begin bad++; $display("FAIL relock_2nd: got %0b want 1", locked); end
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL relock_valid_2nd: got %0b want 0", valid); end
      step(1);
      total++; if (valid !== 1'b1) begin bad++; $display("FAIL relock_valid_3rd: got %0b want 1", valid); end
   endtask

   task automatic test_reset_mid();
      m_mode = 1;
      repeat (PERIOD - 1) step(0);
      step(1);
      total++; if (err_out !== 1'b1) begin bad++; $display("FAIL rmid_pre_err: got %0b want 1", err_out); end
      repeat (2000) step(0);
      rst = 1'b1;
      #1;
      total++; if ({err_out, con_out, act_out, locked, valid} !== 5'b00000)
         begin bad++; $display("FAIL rmid_async_clear: got %b%b%b%b%b want 00000", err_out, con_out, act_out, locked, valid); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      repeat (PERIOD - 2001) step(0);
      valid_seen = 0;
      step(1);
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL rmid_valid_1st: got %0b want 0", valid); end
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL rmid_locked_1st: got %0b want 0", locked); end
      repeat (PERIOD - 1) step(0);
      step(1);
      total++; if (locked !== 1'b1) begin bad++; $display("FAIL rmid_locked_2nd: got %0b want 1", locked); end
      total++; if (valid_seen != 0) begin bad++; $display("FAIL rmid_valid_count: got %0d want 0", valid_seen); end
   endtask

   initial begin
      rst = 1'b1;
      led_in = '0;
      rep = 1'b0;
      m_mode = 0; m_kind = 0; m_chg = 0; valid_seen = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      test_error();
      test_activity();
      test_connected();
      test_idle();
      test_random();
      test_back_to_back();
      test_watchdog();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
